tiny_soc_mmio_sink: RTL
=======================

// Module: tiny_soc_mmio_sink
//
// PURPOSE
// - Write-only MMIO target directly downstream of rocket_mem_top's mmio_* request port in top_tiny_soc.
// - Decodes core MMIO stores into three results:
//   - a sticky stop/exit code,
//   - a buffered console character stream, drained by the bench over a valid/ready handshake,
//   - a watchdog timeout.
// - The port has no grant or response, so the sink accepts every request in the cycle it is presented.
//
// PARAMETERS
// - MMIOAddrWidth   31         width of mmio_addr_i
// - DataWidth       64         width of mmio_wdata_i
// - StrbWidth       8          DataWidth/8
// - FifoDepth       8          character FIFO entries; power of two, >=2
// - TimeoutCycles   1_000_000  cycles after reset with no stop before timeout_o asserts; >0
//
// PORTS
// - clk_i          in   1              clock
// - rst_i          in   1              synchronous reset, active-high
// - mmio_req_i     in   1              MMIO request valid
// - mmio_we_i      in   1              1 = write, 0 = read
// - mmio_addr_i    in   MMIOAddrWidth  byte address
// - mmio_strb_i    in   StrbWidth      byte enables
// - mmio_wdata_i   in   DataWidth      write data
// - char_valid_o   out  1              FIFO head valid
// - char_ready_i   in   1              bench consumes head
// - char_data_o    out  8              FIFO head byte
// - stop_o         out  1              sticky: stop written
// - stop_code_o    out  32             code of the first stop write
// - timeout_o      out  1              sticky: watchdog expired
// - overflow_o     out  1              sticky: character dropped because FIFO full
// - unmapped_o     out  1              sticky: read, or write to an undecoded address
// - cycle_count_o  out  32             cycles since reset; freezes on stop or timeout
//
// BEHAVIOUR
// Reset
// - While rst_i is high at a clock edge, every output is 0 and the FIFO is emptied.
// - Reset wins over any request presented in the same cycle.
// - Reset asserted mid-stream discards all buffered characters.
//
// Access classes (evaluated per cycle)
// - wr = mmio_req_i & mmio_we_i & (mmio_strb_i != 0)
// - A strb==0 write is a no-op and does not set unmapped_o.
// - Address decode is on mmio_addr_i[MMIOAddrWidth-1:3]; low three bits are ignored.
//
// STOP_ADDR = 'h0
// - wr and !stop_o: next cycle stop_o = 1 and stop_code_o = mmio_wdata_i[31:0].
// - Later stop writes are ignored; the first code is kept.
//
// PUTC_ADDR = 'h10
// - wr & mmio_strb_i[0]: push mmio_wdata_i[7:0].
// - wr with strb[0] = 0 is a no-op.
//
// Other accesses
// - Write to any other address, or any read (req & !we): unmapped_o = 1 next cycle.
// - Read data does not exist on this interface.
//
// FIFO
// - Synchronous, registered storage; push-to-char_valid_o latency is 1 cycle.
// - Pop when char_valid_o & char_ready_i.
// - Head byte is stable while valid & !ready.
// - Full and push with no pop in the same cycle: byte dropped, overflow_o = 1 next cycle.
// - Full and push with pop in the same cycle: both occur, occupancy unchanged, no overflow.
// - Empty: char_valid_o = 0 and char_data_o = 0. A pop request while empty is ignored.
// - Pointers wrap modulo FifoDepth; occupancy is held in a counter of clog2(FifoDepth)+1 bits.
// - Characters are still accepted after stop_o or timeout_o assert.
//
// Watchdog
// - cycle_count_o increments every cycle while !stop_o & !timeout_o.
// - It saturates at 32'hFFFF_FFFF.
// - When cycle_count_o == TimeoutCycles-1 and no stop write is accepted that cycle: timeout_o = 1 next cycle and the count freezes.
// - Stop and timeout in the same cycle: stop wins and timeout_o stays 0.
//
// STRUCTURE
// - Package tiny_soc_mmio_pkg holds:
//   - STOP_ADDR and PUTC_ADDR localparams,
//   - char_t = logic [7:0],
//   - mmio_addr_t.
// - One sub-module, tiny_soc_char_fifo (params Depth; push/data, pop/head, full/empty).
// - The decoder, sticky flags and watchdog live in the top module.
//
// TESTING
// 1. Reset 3 cycles with mmio_req_i held at 1.
//    -> All outputs 0, no push or stop.
// 2. Write 'h10, data 'h41, strb 'h01; ready=1.
//    -> char_valid_o=1 with 'h41 for exactly 1 cycle, starting 1 cycle after the write.
// 3. Hold ready=0 and write 9 chars 'h30..'h38 (FifoDepth 8).
//    -> overflow_o=1 after the 9th write.
//    -> Draining yields 'h30..'h37 in order, then valid=0.
// 4. Full FIFO, ready=1 and putc 'h5A in the same cycle.
//    -> No overflow, occupancy stays 8, 'h5A emerges last.
// 5. Write 'h0 with data 'h1, then write 'h0 with data 'h7.
//    -> stop_o=1, stop_code_o='h1, cycle_count_o frozen.
// 6. TimeoutCycles=16 with no stop.
//    -> timeout_o rises 16 cycles after reset release.
//    -> A read at 'h20 sets unmapped_o; a strb=0 write to 'h20 does not.

Source files
------------

// File: rtl/tiny_soc_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tiny_soc_mmio_pkg
// Description : Shared types and MMIO address map for the tiny SoC MMIO sink.
//               STOP_ADDR receives the exit code, PUTC_ADDR receives console
//               characters. Decode ignores the low three (byte-in-word) bits.
// Revision    : 1.0 - initial release
// ============================================================================
package tiny_soc_mmio_pkg;

    localparam int MMIO_ADDR_WIDTH = 31;

    typedef logic [MMIO_ADDR_WIDTH-1:0] mmio_addr_t;
    typedef logic [7:0]                 char_t;

    localparam mmio_addr_t STOP_ADDR = 31'h0000_0000;
    localparam mmio_addr_t PUTC_ADDR = 31'h0000_0010;

endpackage : tiny_soc_mmio_pkg
`default_nettype wire

// File: rtl/tiny_soc_mmio_sink_if.sv
`default_nettype none
// ============================================================================
// Module      : tiny_soc_mmio_sink_if
// Description : MMIO request port (no grant, no response) plus the console
//               character valid/ready stream.
//   mmio_req_i/we_i/addr_i/strb_i/wdata_i : core -> sink store request
//   char_valid_o/char_data_o              : sink -> consumer FIFO head
//   char_ready_i                          : consumer -> sink, pops the head
// Revision    : 1.0 - initial release
// ============================================================================
interface tiny_soc_mmio_sink_if
    import tiny_soc_mmio_pkg::*;
#(
    parameter int MMIO_ADDR_WIDTH = 31,
    parameter int DATA_WIDTH      = 64,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8
);
    logic                       mmio_req_i;
    logic                       mmio_we_i;
    logic [MMIO_ADDR_WIDTH-1:0] mmio_addr_i;
    logic [STRB_WIDTH-1:0]      mmio_strb_i;
    logic [DATA_WIDTH-1:0]      mmio_wdata_i;
    logic                       char_valid_o;
    logic                       char_ready_i;
    char_t                      char_data_o;

    modport master (
        output mmio_req_i, mmio_we_i, mmio_addr_i, mmio_strb_i, mmio_wdata_i,
        output char_ready_i,
        input  char_valid_o, char_data_o
    );

    modport slave (
        input  mmio_req_i, mmio_we_i, mmio_addr_i, mmio_strb_i, mmio_wdata_i,
        input  char_ready_i,
        output char_valid_o, char_data_o
    );

endinterface : tiny_soc_mmio_sink_if
`default_nettype wire

// File: rtl/tiny_soc_char_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tiny_soc_char_fifo
// Description : Synchronous character FIFO with registered storage.
//   clk, rst      : clock, synchronous active-high reset (empties FIFO)
//   i_push/i_data : write request and byte
//   i_pop         : pop request (ignored while empty)
//   o_head        : head byte, 0 while empty
//   o_full/o_empty: occupancy flags
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is dropped (the caller flags the overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module tiny_soc_char_fifo
    import tiny_soc_mmio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire   clk,
    input  wire   rst,
    input  wire   i_push,
    input  char_t i_data,
    input  wire   i_pop,
    output char_t o_head,
    output logic  o_full,
    output logic  o_empty
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    char_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // Full is fine when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule : tiny_soc_char_fifo
`default_nettype wire

// File: rtl/tiny_soc_mmio_sink.sv
`default_nettype none
// ============================================================================
// Module      : tiny_soc_mmio_sink
// Description : Write-only MMIO target. Decodes core stores into a sticky
//               stop/exit code, a buffered console character stream and a
//               watchdog timeout. Every request is accepted in the cycle it
//               is presented.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   bus            : MMIO request + character stream (slave modport)
//   stop_o         : sticky, stop written
//   stop_code_o    : code of the first stop write
//   timeout_o      : sticky, watchdog expired
//   overflow_o     : sticky, character dropped on a full FIFO
//   unmapped_o     : sticky, read or write to an undecoded address
//   cycle_count_o  : cycles since reset, frozen on stop or timeout
// Revision    : 1.0 - initial release
// ============================================================================
module tiny_soc_mmio_sink
    import tiny_soc_mmio_pkg::*;
#(
    parameter int          MMIO_ADDR_WIDTH = 31,
    parameter int          DATA_WIDTH      = 64,
    parameter int          FIFO_DEPTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1_000_000
) (
    input  wire                   clk_i,
    input  wire                   rst_i,
    tiny_soc_mmio_sink_if.slave   bus,
    output logic                  stop_o,
    output logic [31:0]           stop_code_o,
    output logic                  timeout_o,
    output logic                  overflow_o,
    output logic                  unmapped_o,
    output logic [31:0]           cycle_count_o
);
    localparam int                       c_WORD_W    = MMIO_ADDR_WIDTH - 3;
    localparam logic [c_WORD_W-1:0]      c_STOP_WORD = c_WORD_W'(STOP_ADDR >> 3);
    localparam logic [c_WORD_W-1:0]      c_PUTC_WORD = c_WORD_W'(PUTC_ADDR >> 3);
    localparam logic [31:0]              c_TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    logic        r_stop;
    logic [31:0] r_stop_code;
    logic        r_timeout;
    logic        r_overflow;
    logic        r_unmapped;
    logic [31:0] r_count;

    logic [c_WORD_W-1:0] w_word;
    logic                w_wr;
    logic                w_rd;
    logic                w_hit_stop;
    logic                w_hit_putc;
    logic                w_stop_wr;
    logic                w_push;
    logic                w_pop;
    logic                w_unmapped;
    logic                w_overflow;
    logic                w_timeout_hit;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_unused_bits;

    assign w_word     = bus.mmio_addr_i[MMIO_ADDR_WIDTH-1:3];
    assign w_wr       = bus.mmio_req_i & bus.mmio_we_i & (|bus.mmio_strb_i);
    assign w_rd       = bus.mmio_req_i & ~bus.mmio_we_i;
    assign w_hit_stop = (w_word == c_STOP_WORD);
    assign w_hit_putc = (w_word == c_PUTC_WORD);

    // Only the first stop write is captured; later ones are silently ignored.
    assign w_stop_wr  = w_wr & w_hit_stop & ~r_stop;
    assign w_push     = w_wr & w_hit_putc & bus.mmio_strb_i[0];
    assign w_unmapped = w_rd | (w_wr & ~w_hit_stop & ~w_hit_putc);

    assign w_pop      = bus.char_ready_i & ~w_fifo_empty;
    assign w_overflow = w_push & w_fifo_full & ~w_pop;

    // A stop accepted in the expiry cycle takes priority over the timeout.
    assign w_timeout_hit = ~r_stop & ~r_timeout & (r_count == c_TO_LAST) & ~w_stop_wr;

    assign w_unused_bits = ^{bus.mmio_wdata_i[DATA_WIDTH-1:32], bus.mmio_addr_i[2:0]};

    tiny_soc_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_data  (bus.mmio_wdata_i[7:0]),
        .i_pop   (bus.char_ready_i),
        .o_head  (bus.char_data_o),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign bus.char_valid_o = ~w_fifo_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stop      <= 1'b0;
            r_stop_code <= '0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            r_unmapped  <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_stop_wr) begin
                r_stop      <= 1'b1;
                r_stop_code <= bus.mmio_wdata_i[31:0];
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
            if (w_overflow) begin
                r_overflow <= 1'b1;
            end
            if (w_unmapped) begin
                r_unmapped <= 1'b1;
            end
            // Counts on the current flag values, so the stopping/expiring
            // cycle is itself counted before the freeze.
            if (!r_stop && !r_timeout && (r_count != 32'hFFFF_FFFF)) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign stop_o        = r_stop;
    assign stop_code_o   = r_stop_code;
    assign timeout_o     = r_timeout;
    assign overflow_o    = r_overflow;
    assign unmapped_o    = r_unmapped;
    assign cycle_count_o = r_count;

endmodule : tiny_soc_mmio_sink
`default_nettype wire
